// File: rtl/i2c_bus_monitor_pkg.sv
// Shared definitions for the I2C bus monitor: default widths, the ACK slot
// index, the bus-event bundle and the helpers that decode and step it.
package i2c_bus_monitor_pkg;

    localparam int FILT_W_DEF   = 4;
    localparam int IDLE_W_DEF   = 12;
    localparam int IDLE_CYC_DEF = 1000;
    localparam int BIT_IDX_W    = 4;

    // Ninth bit of every frame is the ACK slot.
    localparam logic [BIT_IDX_W-1:0] ACK_BIT_IDX = 4'd8;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } bus_events_t;

    // START/STOP need SCL stable high across both samples, so a simultaneous
    // SCL and SDA change only ever reports the SCL edge.
    function automatic bus_events_t decode_events(input logic scl_p, input logic scl_c,
                                                  input logic sda_p, input logic sda_c);
        bus_events_t ev;
        ev.scl_rise = !scl_p & scl_c;
        ev.scl_fall = scl_p & !scl_c;
        ev.start    = scl_p & scl_c & sda_p & !sda_c;
        ev.stop     = scl_p & scl_c & !sda_p & sda_c;
        return ev;
    endfunction

    function automatic logic [BIT_IDX_W-1:0] next_bit_idx(input logic [BIT_IDX_W-1:0] idx);
        return (idx == ACK_BIT_IDX) ? '0 : idx + BIT_IDX_W'(1);
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a counter glitch filter for one I2C line.
// The filtered output only follows the synchronised input after it has
// disagreed for filt_len+1 consecutive clocks, so pulses of filt_len clocks
// or less are rejected.
//   clk      system clock
//   rst      synchronous reset, active high (line idles high)
//   line_i   raw asynchronous pad input
//   filt_len glitch filter length in clk cycles (quasi-static)
//   line_f   filtered line value
module i2c_glitch_filter
    import i2c_bus_monitor_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_i,
    input  logic [FILT_W-1:0] filt_len,
    output logic              line_f
);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              filt_q, filt_d;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        cnt_d   = '0;
        filt_d  = filt_q;
        if (sync2_q != filt_q) begin
            // >= rather than == keeps the filter live if filt_len shrinks mid-count.
            if (cnt_q >= filt_len) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + FILT_W'(1);
            end
        end
    end

    // NOTE: flops are updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority
        // branch of the clocked update and needs no asynchronous path.
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            filt_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
        end
    end

    assign line_f = filt_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Line-conditioning stage in front of the I2C byte/bit engine. Filters SCL and
// SDA, then derives registered one-cycle events (SCL edges, START, STOP,
// sampled bits), the bit position within each 9-bit frame, bus busy with an
// idle timeout, and a sticky arbitration-lost flag.
//   clk, rst             clock and synchronous active-high reset
//   scl_i, sda_i         raw pad inputs
//   sda_oe               own open-drain SDA drive (1 = pulling low)
//   tx_en                engine is driving the bus; arms the arbitration check
//   filt_len             glitch filter length
//   arb_clr              clears arb_lost
//   scl_f, sda_f         filtered lines
//   scl_rise, scl_fall   filtered SCL edge pulses
//   start_det, stop_det  START / STOP pulses
//   bit_valid, bit_val   sampled bit pulse and value
//   bit_idx              position of the last sampled bit, 0..8 (8 = ACK)
//   bus_busy             bus owned between START and STOP/timeout
//   arb_lost             sticky arbitration-lost flag
module i2c_bus_monitor
    import i2c_bus_monitor_pkg::*;
#(
    parameter int FILT_W   = FILT_W_DEF,
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int IDLE_CYC = IDLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic              sda_oe,
    input  logic              tx_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              arb_clr,
    output logic              scl_f,
    output logic              sda_f,
    output logic              scl_rise,
    output logic              scl_fall,
    output logic              start_det,
    output logic              stop_det,
    output logic              bit_valid,
    output logic              bit_val,
    output logic [3:0]        bit_idx,
    output logic              bus_busy,
    output logic              arb_lost
);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_CYC);

    i2c_glitch_filter #(.FILT_W(FILT_W)) u_scl_filt (
        .clk(clk), .rst(rst), .line_i(scl_i), .filt_len(filt_len), .line_f(scl_f)
    );

    i2c_glitch_filter #(.FILT_W(FILT_W)) u_sda_filt (
        .clk(clk), .rst(rst), .line_i(sda_i), .filt_len(filt_len), .line_f(sda_f)
    );

    logic              scl_p_q, scl_p_d;
    logic              sda_p_q, sda_p_d;
    bus_events_t       ev_q, ev_d;
    logic              bit_val_q, bit_val_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [3:0]        next_idx_q, next_idx_d;
    logic              busy_q, busy_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              arb_lost_q, arb_lost_d;
    logic              idle_run;
    logic              idle_timeout;
    logic              arb_set;

    always_comb begin
        scl_p_d    = scl_f;
        sda_p_d    = sda_f;
        ev_d       = decode_events(scl_p_q, scl_f, sda_p_q, sda_f);
        bit_val_d  = bit_val_q;
        bit_idx_d  = bit_idx_q;
        next_idx_d = next_idx_q;
        busy_d     = busy_q;

        if (ev_d.scl_rise) begin
            bit_val_d = sda_f;
        end

        // next_idx holds the slot the coming bit will occupy; bit_idx reports
        // the slot of the bit just sampled.
        if (ev_d.start) begin
            bit_idx_d  = '0;
            next_idx_d = '0;
        end else if (ev_d.scl_rise && busy_q) begin
            bit_idx_d  = next_idx_q;
            next_idx_d = next_bit_idx(next_idx_q);
        end

        idle_run     = scl_f & sda_f & busy_q;
        idle_cnt_d   = idle_run ? idle_cnt_q + IDLE_W'(1) : '0;
        idle_timeout = (IDLE_CYC != 0) && idle_run && (idle_cnt_q == IDLE_LIMIT - IDLE_W'(1));

        // START is checked first so it wins over a same-cycle timeout.
        if (ev_d.start) begin
            busy_d = 1'b1;
        end else if (ev_d.stop || idle_timeout) begin
            busy_d = 1'b0;
        end

        // Lost arbitration: we released SDA but saw it low on a sampling edge,
        // or a START/STOP appeared while we were not pulling SDA.
        arb_set    = tx_en & !sda_oe & ((ev_d.scl_rise & !sda_f) | ev_d.start | ev_d.stop);
        arb_lost_d = arb_set ? 1'b1 : (arb_clr ? 1'b0 : arb_lost_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            ev_q       <= '0;
            bit_val_q  <= 1'b0;
            bit_idx_q  <= '0;
            next_idx_q <= '0;
            busy_q     <= 1'b0;
            idle_cnt_q <= '0;
            arb_lost_q <= 1'b0;
        end else begin
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
            ev_q       <= ev_d;
            bit_val_q  <= bit_val_d;
            bit_idx_q  <= bit_idx_d;
            next_idx_q <= next_idx_d;
            busy_q     <= busy_d;
            idle_cnt_q <= idle_cnt_d;
            arb_lost_q <= arb_lost_d;
        end
    end

    assign scl_rise  = ev_q.scl_rise;
    assign scl_fall  = ev_q.scl_fall;
    assign start_det = ev_q.start;
    assign stop_det  = ev_q.stop;
    assign bit_valid = ev_q.scl_rise;
    assign bit_val   = bit_val_q;
    assign bit_idx   = bit_idx_q;
    assign bus_busy  = busy_q;
    assign arb_lost  = arb_lost_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor. Bus stimulus pushes the expected
// START/STOP/bit events into a queue; a negedge monitor pops and compares each
// event as the DUT pulses it. Level outputs are checked directly.
module tb_i2c_bus_monitor;

    localparam int Q = 10;  // pad clocks per bus phase, longer than the filter latency

    typedef enum logic [1:0] {EV_START, EV_STOP, EV_BIT} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic       val;
        logic [3:0] idx;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_i, sda_i, sda_oe, tx_en, arb_clr;
    logic [3:0] filt_len;
    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic       bit_valid, bit_val, bus_busy, arb_lost;
    logic [3:0] bit_idx;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    i2c_bus_monitor #(.FILT_W(4), .IDLE_W(12), .IDLE_CYC(20)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .tx_en(tx_en), .filt_len(filt_len), .arb_clr(arb_clr),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .bit_valid(bit_valid),
        .bit_val(bit_val), .bit_idx(bit_idx), .bus_busy(bus_busy), .arb_lost(arb_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_e kind, input logic val, input logic [3:0] idx,
                           input logic busy);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.idx  = idx;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input ev_kind_e kind);
        exp_t e;
        logic ok;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got unexpected %s (val=%b idx=%0d busy=%b), none expected",
                     kind.name(), bit_val, bit_idx, bus_busy);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind) && (bus_busy === e.busy);
            if (kind == EV_BIT) ok = ok && (bit_val === e.val) && (bit_idx === e.idx);
            if (!ok) begin
                n_fail++;
                $display("FAIL event: got %s val=%b idx=%0d busy=%b, expected %s val=%b idx=%0d busy=%b",
                         kind.name(), bit_val, bit_idx, bus_busy,
                         e.kind.name(), e.val, e.idx, e.busy);
            end
        end
    endtask

    // Scoreboard monitor: one pop per event pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_det === 1'b1) match_ev(EV_START);
        if (stop_det  === 1'b1) match_ev(EV_STOP);
        if (bit_valid === 1'b1) match_ev(EV_BIT);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        push_ev(EV_START, 1'b0, 4'd0, 1'b1);
        sda_i = 1'b0; wait_n(Q);
        scl_i = 1'b0; wait_n(Q);
    endtask

    task automatic i2c_bit(input logic b, input logic [3:0] idx, input logic busy);
        sda_i = b; wait_n(Q);
        push_ev(EV_BIT, b, idx, busy);
        scl_i = 1'b1; wait_n(Q);
        scl_i = 1'b0; wait_n(Q);
    endtask

    // The SCL rise inside a STOP is itself a sampled bit.
    task automatic i2c_stop(input logic [3:0] idx);
        sda_i = 1'b0; wait_n(Q);
        push_ev(EV_BIT, 1'b0, idx, 1'b1);
        scl_i = 1'b1; wait_n(Q);
        push_ev(EV_STOP, 1'b0, 4'd0, 1'b0);
        sda_i = 1'b1; wait_n(Q);
    endtask

    task automatic i2c_rstart(input logic [3:0] idx);
        sda_i = 1'b1; wait_n(Q);
        push_ev(EV_BIT, 1'b1, idx, 1'b1);
        scl_i = 1'b1; wait_n(Q);
        push_ev(EV_START, 1'b0, 4'd0, 1'b1);
        sda_i = 1'b0; wait_n(Q);
        scl_i = 1'b0; wait_n(Q);
    endtask

    initial begin
        logic       held_high;
        logic [7:0] byte_a5;
        logic [3:0] rs_bits;

        rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1; sda_oe = 1'b0;
        tx_en = 1'b0; arb_clr = 1'b0; filt_len = 4'd3;

        // 1: reset release with idle lines
        wait_n(4);
        rst = 1'b0;
        wait_n(Q);
        check("reset scl_f", scl_f, 1);
        check("reset sda_f", sda_f, 1);
        check("reset bus_busy", bus_busy, 0);
        check("reset bit_idx", bit_idx, 0);
        check("reset arb_lost", arb_lost, 0);

        // 2: 3-clk SDA glitch rejected; 4-clk low passes 6 clk after pad edge
        sda_i = 1'b0; wait_n(3);
        sda_i = 1'b1;
        held_high = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sda_f !== 1'b1) held_high = 1'b0;
        end
        check("glitch 3clk sda_f held", held_high, 1);
        push_ev(EV_START, 1'b0, 4'd0, 1'b1);
        push_ev(EV_STOP, 1'b0, 4'd0, 1'b0);
        sda_i = 1'b0; wait_n(4);
        sda_i = 1'b1; wait_n(1);
        check("pulse 4clk sda_f at +5", sda_f, 1);
        wait_n(1);
        check("pulse 4clk sda_f at +6", sda_f, 0);
        wait_n(2 * Q);

        // 3: START, 0xA5, ACK=0, STOP
        byte_a5 = 8'hA5;
        i2c_start();
        check("byte bus_busy after start", bus_busy, 1);
        for (int i = 0; i < 8; i++) i2c_bit(byte_a5[7-i], 4'(i), 1'b1);
        i2c_bit(1'b0, 4'd8, 1'b1);
        check("byte bit_idx at ack", bit_idx, 8);
        i2c_stop(4'd0);
        check("byte bus_busy after stop", bus_busy, 0);

        // 4: repeated START when the sampled bit reports index 4
        rs_bits = 4'b1101;
        i2c_start();
        for (int i = 0; i < 4; i++) i2c_bit(rs_bits[3-i], 4'(i), 1'b1);
        check("rstart bit_idx before", bit_idx, 3);
        i2c_rstart(4'd4);
        check("rstart bit_idx reset", bit_idx, 0);
        check("rstart bus_busy", bus_busy, 1);
        i2c_bit(1'b0, 4'd0, 1'b1);
        i2c_stop(4'd1);

        // 5: arbitration loss, clear, and set-wins-over-clear
        i2c_start();
        tx_en = 1'b1; sda_oe = 1'b0;
        i2c_bit(1'b0, 4'd0, 1'b1);
        check("arb set on released low", arb_lost, 1);
        arb_clr = 1'b1; wait_n(1);
        arb_clr = 1'b0;
        check("arb cleared", arb_lost, 0);
        sda_i = 1'b0; wait_n(Q);
        push_ev(EV_BIT, 1'b0, 4'd1, 1'b1);
        scl_i = 1'b1; wait_n(6);
        arb_clr = 1'b1; wait_n(1);
        arb_clr = 1'b0;
        check("arb set+clr scl_rise aligned", scl_rise, 1);
        check("arb set wins over clr", arb_lost, 1);
        wait_n(Q - 7);
        scl_i = 1'b0; wait_n(Q);
        arb_clr = 1'b1; wait_n(1);
        arb_clr = 1'b0;
        sda_oe = 1'b1;
        i2c_bit(1'b0, 4'd2, 1'b1);
        check("arb not set when driving low", arb_lost, 0);
        tx_en = 1'b0; sda_oe = 1'b0;
        i2c_stop(4'd3);

        // 6: idle timeout after 20 clk of both lines high
        i2c_start();
        sda_i = 1'b1; wait_n(Q);
        push_ev(EV_BIT, 1'b1, 4'd0, 1'b1);
        scl_i = 1'b1; wait_n(25);
        check("idle busy before timeout", bus_busy, 1);
        wait_n(1);
        check("idle busy after timeout", bus_busy, 0);
        wait_n(Q);

        // 6b: reset mid-byte with arb_lost set and SCL low
        i2c_start();
        i2c_bit(1'b1, 4'd0, 1'b1);
        tx_en = 1'b1;
        i2c_bit(1'b0, 4'd1, 1'b1);
        tx_en = 1'b0;
        i2c_bit(1'b1, 4'd2, 1'b1);
        check("pre-reset arb_lost", arb_lost, 1);
        rst = 1'b1; wait_n(1);
        check("mid reset scl_f", scl_f, 1);
        check("mid reset sda_f", sda_f, 1);
        check("mid reset pulses", {scl_rise, scl_fall, start_det, stop_det, bit_valid}, 0);
        check("mid reset bit_idx", bit_idx, 0);
        check("mid reset bus_busy", bus_busy, 0);
        check("mid reset arb_lost", arb_lost, 0);
        rst = 1'b0; wait_n(Q);
        check("post reset scl_f follows pad", scl_f, 0);
        push_ev(EV_BIT, 1'b1, 4'd0, 1'b0);
        scl_i = 1'b1; wait_n(Q);
        check("post reset bit_idx unchanged", bit_idx, 0);

        check("expected events drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
